// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier on MUL* ops.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      control,
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic                r_neg;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;

    logic                w_sa, w_sb, w_neg_a, w_neg_b;
    logic [XLEN-1:0]     w_mag_a, w_mag_b;
    logic                w_zero_div, w_ovf, w_special, w_fast, w_accept;
    logic [XLEN-1:0]     w_spec_res, w_idle_res, w_calc_res;
    logic [XLEN:0]       w_sum, w_rem_sh, w_trial;
    logic [2*XLEN-1:0]   w_acc_step, w_prod;
    logic [XLEN-1:0]     w_dval;

    // DIVU/REMU/MULHU treat both operands as unsigned, MULHSU only d2
    assign w_sa    = ~(control[0] & (control[1] | control[2]));
    assign w_sb    = w_sa & (control != 3'b010);
    assign w_neg_a = w_sa & d1[XLEN-1];
    assign w_neg_b = w_sb & d2[XLEN-1];
    assign w_mag_a = w_neg_a ? -d1 : d1;
    assign w_mag_b = w_neg_b ? -d2 : d2;

    assign w_zero_div = control[2] & (d2 == '0);
    assign w_ovf      = control[2] & ~control[0]
                      & (d1 == {1'b1, {(XLEN-1){1'b0}}})
                      & (d2 == '1);
    assign w_special  = w_zero_div | w_ovf;
    assign w_spec_res = w_zero_div ? (control[1] ? d1 : '1)
                                   : (control[1] ? '0 : d1);
    assign w_accept   = (r_state == S_IDLE) & start & ~flush;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fp;
    logic [XLEN-1:0]   w_fast_res;
    assign w_fa       = {{XLEN{w_neg_a}}, d1};
    assign w_fb       = {{XLEN{w_neg_b}}, d2};
    assign w_fp       = w_fa * w_fb;
    assign w_fast_res = (control[1:0] == 2'b00) ? w_fp[XLEN-1:0]
                                                : w_fp[2*XLEN-1:XLEN];
    assign w_fast     = ~control[2];
    assign w_idle_res = w_special ? w_spec_res : w_fast_res;
`else
    assign w_fast     = 1'b0;
    assign w_idle_res = w_spec_res;
`endif

    // acc = {partial/remainder, multiplier/dividend-quotient}
    assign w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]}
                    + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
    assign w_trial  = w_rem_sh - {1'b0, r_b};

    always_comb begin
        if (r_op[2]) begin
            if (w_trial[XLEN])
                w_acc_step = {r_acc[2*XLEN-2:0], 1'b0};
            else
                w_acc_step = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_acc_step = {w_sum, r_acc[XLEN-1:1]};
        end
    end

    always_comb begin
        w_prod = r_neg ? -w_acc_step : w_acc_step;
        w_dval = r_op[1] ? w_acc_step[2*XLEN-1:XLEN]
                         : w_acc_step[XLEN-1:0];
        if (r_op[2])
            w_calc_res = r_neg ? -w_dval : w_dval;
        else if (r_op[1:0] == 2'b00)
            w_calc_res = w_prod[XLEN-1:0];
        else
            w_calc_res = w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start)
                            w_next = (w_special | w_fast) ? S_FIN : S_CALC;
                S_CALC: if (r_cnt == CNT_W'(XLEN-1))
                            w_next = S_FIN;
                S_FIN:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_CALC);
        done = (r_state == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= control;
                r_neg <= (control == 3'b110) ? w_neg_a : (w_neg_a ^ w_neg_b);
                r_b   <= w_mag_b;
                r_acc <= {{XLEN{1'b0}}, w_mag_a};
                r_cnt <= '0;
            end else if (r_state == S_CALC && !flush) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_next == S_FIN)
                r_result <= (r_state == S_IDLE) ? w_idle_res : w_calc_res;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, protocol
// corner cases and randomized ops against a plain-arithmetic reference.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  control = 3'd0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = '0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .d1(d1), .d2(d2), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] c,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = a;
        ib = b;
        case (c)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] c,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        if (c[2] && (b == 0 ||
            (!c[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!c[2]) return 1;
`endif
        return 33;
    endfunction

    // Leaves the bench 1 time unit after the accepting edge (cycle 1)
    task automatic start_op(input logic [2:0] c, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        control = c;
        d1 = a;
        d2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        control = 3'($urandom);
        d1 = $urandom;
        d2 = $urandom;
    endtask

    task automatic wait_done(input string tag, input int lat,
                             input logic [31:0] exp, input int rs_cyc);
        int cyc;
        bit seen;
        bit busy_ok;
        seen = 1'b0;
        busy_ok = 1'b1;
        for (cyc = 1; cyc <= 80; cyc++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == rs_cyc) begin
                start = 1'b1;
                control = 3'($urandom);
                d1 = $urandom;
                d2 = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk({tag, ":done_seen"}, 32'(seen), 32'd1);
        chk({tag, ":latency"}, 32'(cyc), 32'(lat));
        chk({tag, ":result"}, result, exp);
        chk({tag, ":busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, ":busy_at_done"}, 32'(busy), 32'd0);
        last_res = exp;
        @(posedge clk);
        #1;
        chk({tag, ":done_pulse"}, 32'(done), 32'd0);
        chk({tag, ":result_hold"}, result, exp);
    endtask

    task automatic run(input string tag, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        start_op(c, a, b);
        wait_done(tag, lat_of(c, a, b), exp, 0);
    endtask

    task automatic no_done(input string tag, input int n);
        bit quiet;
        quiet = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        chk({tag, ":quiet"}, 32'(quiet), 32'd1);
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] a, b;

        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run("mul_tp", 3'd0, 32'hF31474A1, 32'h00000003, 32'hD93D5DE3);
        run("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        run("remu", 3'd7, 32'd100, 32'd7, 32'd2);
        run("divu_by0", 3'd5, 32'd1234, 32'd0, 32'hFFFFFFFF);
        run("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5);
        run("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);

        start_op(3'd5, 32'd100, 32'd7);
        wait_done("restart_ignored", 33, 32'd14, 10);

        start_op(3'd5, 32'hDEADBEEF, 32'h00000123);
        for (int i = 1; i < 15; i++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result", result, last_res);
        no_done("flush", 40);
        chk("flush_result_after", result, last_res);

        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        control = 3'd5;
        d1 = 32'd50;
        d2 = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        chk("flush_start_done", 32'(done), 32'd0);
        no_done("flush_start", 40);
        chk("flush_start_result", result, last_res);

        start_op(3'd5, 32'd9, 32'd0);
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_result", result, 32'hFFFFFFFF);
        last_res = 32'hFFFFFFFF;
        start = 1'b1;
        control = 3'd5;
        d1 = 32'd100;
        d2 = 32'd7;
        @(posedge clk);
        #1;
        chk("b2b_ignored_busy", 32'(busy), 32'd0);
        chk("b2b_ignored_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_next", 33, 32'd14, 0);

        start_op(3'd4, 32'h7654321, 32'd3);
        for (int i = 1; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        last_res = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        no_done("midrst", 40);

        for (int n = 0; n < 48; n++) begin
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 17));
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            start_op(c, a, b);
            wait_done($sformatf("rand%0d_op%0d", n, c), lat_of(c, a, b),
                      ref_model(c, a, b), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
